// File: rtl/leds_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : leds_seq_ctrl
// Brief    : Eight-LED bar sequencer. A prescaler produces a step strobe and a
//            mode/speed state machine drives SCAN, FILL or BLINK patterns.
//            Optional macro LEDS_SEQ_PAUSE_EN adds a pause_btn input that
//            toggles an internal paused flag.
// Revision : 1.0 - initial release
// ============================================================================
module leds_seq_ctrl #(
   parameter int TICK_DIV = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       mode_btn,
   input  logic       speed_btn,
`ifdef LEDS_SEQ_PAUSE_EN
   input  logic       pause_btn,
`endif
   output logic [7:0] leds,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       tick
);

   // Prescaler width covers the slowest terminal count (TICK_DIV - 1).
   localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Terminal counts for each speed level: (TICK_DIV >> speed) - 1.
   localparam logic [c_cnt_w-1:0] c_term_s0 = c_cnt_w'((TICK_DIV >> 0) - 1);
   localparam logic [c_cnt_w-1:0] c_term_s1 = c_cnt_w'((TICK_DIV >> 1) - 1);
   localparam logic [c_cnt_w-1:0] c_term_s2 = c_cnt_w'((TICK_DIV >> 2) - 1);
   localparam logic [c_cnt_w-1:0] c_term_s3 = c_cnt_w'((TICK_DIV >> 3) - 1);

   typedef enum logic [1:0] {
      MODE_SCAN  = 2'd0,
      MODE_FILL  = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BAD   = 2'd3
   } mode_t;

   mode_t              r_mode;
   logic [1:0]         r_speed;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_pos;
   logic               r_dir_up;
   logic [3:0]         r_k;
   logic               r_phase;
   logic [7:0]         r_leds;

   logic [c_cnt_w-1:0] w_term;
   logic               w_at_term;
   logic               w_run;
   logic               w_paused;
   logic [2:0]         w_next_pos;
   logic               w_next_dir_up;
   logic [3:0]         w_next_k;

`ifdef LEDS_SEQ_PAUSE_EN
   logic               r_paused;

   // Paused flag: each pause_btn pulse flips it, independent of the other buttons.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_paused <= 1'b0;
      end else if (pause_btn) begin
         r_paused <= ~r_paused;
      end
   end

   assign w_paused = r_paused;
`else
   assign w_paused = 1'b0;
`endif

   // Select the prescaler terminal count for the current speed level.
   always_comb begin
      w_term = c_term_s0;
      case (r_speed)
         2'd0:    w_term = c_term_s0;
         2'd1:    w_term = c_term_s1;
         2'd2:    w_term = c_term_s2;
         default: w_term = c_term_s3;
      endcase
   end

   assign w_at_term = (r_cnt == w_term);
   assign w_run     = enable & ~w_paused;
   assign tick      = w_run & w_at_term;

   // Next SCAN position: bounce between 7 and 0, flipping direction on arrival
   // at an end so neither end value is shown twice in a row.
   always_comb begin
      w_next_pos    = r_pos;
      w_next_dir_up = r_dir_up;
      if (r_dir_up) begin
         w_next_pos = r_pos + 3'd1;
         if (r_pos == 3'd6) begin
            w_next_dir_up = 1'b0;
         end
      end else begin
         w_next_pos = r_pos - 3'd1;
         if (r_pos == 3'd1) begin
            w_next_dir_up = 1'b1;
         end
      end
   end

   // Next FILL level: 0..8 then wrap to 0.
   assign w_next_k = (r_k >= 4'd8) ? 4'd0 : (r_k + 4'd1);

   // Mode/speed state machine, prescaler and registered LED pattern.
   // Buttons take priority over a step; any button edge clears the prescaler
   // and swallows a coincident tick.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mode   <= MODE_SCAN;
         r_speed  <= 2'd0;
         r_cnt    <= '0;
         r_pos    <= 3'd7;
         r_dir_up <= 1'b0;
         r_k      <= 4'd0;
         r_phase  <= 1'b1;
         r_leds   <= 8'h80;
      end else begin
         if (speed_btn) begin
            r_speed <= r_speed + 2'd1;
         end

         if (mode_btn | speed_btn) begin
            r_cnt <= '0;
            if (mode_btn) begin
               case (r_mode)
                  MODE_SCAN: begin
                     r_mode <= MODE_FILL;
                     r_k    <= 4'd0;
                     r_leds <= 8'h00;
                  end
                  MODE_FILL: begin
                     r_mode  <= MODE_BLINK;
                     r_phase <= 1'b1;
                     r_leds  <= 8'hFF;
                  end
                  default: begin
                     // BLINK wraps to SCAN; an illegal code lands here too.
                     r_mode   <= MODE_SCAN;
                     r_pos    <= 3'd7;
                     r_dir_up <= 1'b0;
                     r_leds   <= 8'h80;
                  end
               endcase
            end
         end else if (r_mode == MODE_BAD) begin
            // Unreachable encoding: fall back to a clean SCAN restart.
            r_mode   <= MODE_SCAN;
            r_cnt    <= '0;
            r_pos    <= 3'd7;
            r_dir_up <= 1'b0;
            r_leds   <= 8'h80;
         end else if (w_run) begin
            if (w_at_term) begin
               r_cnt <= '0;
               case (r_mode)
                  MODE_SCAN: begin
                     r_pos    <= w_next_pos;
                     r_dir_up <= w_next_dir_up;
                     r_leds   <= 8'h01 << w_next_pos;
                  end
                  MODE_FILL: begin
                     r_k    <= w_next_k;
                     r_leds <= ~(8'hFF >> w_next_k);
                  end
                  MODE_BLINK: begin
                     r_phase <= ~r_phase;
                     r_leds  <= {8{~r_phase}};
                  end
                  default: begin
                     r_leds <= r_leds;
                  end
               endcase
            end else begin
               r_cnt <= r_cnt + c_cnt_w'(1);
            end
         end
      end
   end

   assign leds  = r_leds;
   assign mode  = r_mode;
   assign speed = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_leds_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_leds_seq_ctrl
// Brief    : Self-checking bench for leds_seq_ctrl (TICK_DIV = 8). Directed
//            steps followed by random button/enable traffic, all compared
//            against a table-driven behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leds_seq_ctrl;

   localparam int c_div = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       mode_btn;
   logic       speed_btn;
   logic       pause_btn;
   logic [7:0] leds;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   leds_seq_ctrl #(.TICK_DIV(c_div)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .enable    (enable),
      .mode_btn  (mode_btn),
      .speed_btn (speed_btn),
`ifdef LEDS_SEQ_PAUSE_EN
      .pause_btn (pause_btn),
`endif
      .leds      (leds),
      .mode      (mode),
      .speed     (speed),
      .tick      (tick)
   );

   // ---------------- behavioural model ----------------
   logic [7:0] scan_tab [14] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
   int  m_mode, m_speed, m_cnt, m_sidx, m_k;
   bit  m_ph, m_paused, m_valid;
   logic obs_tick;

   function automatic int m_term();
      return (c_div >> m_speed) - 1;
   endfunction

   function automatic logic [7:0] m_leds();
      case (m_mode)
         0:       return scan_tab[m_sidx];
         1:       return 8'((255 << (8 - m_k)) & 255);
         default: return m_ph ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit m, input bit s, input bit p);
      bit run;
      if (!r) begin
         m_mode = 0; m_speed = 0; m_cnt = 0; m_sidx = 0; m_k = 0;
         m_ph = 1; m_paused = 0; m_valid = 1;
      end else begin
         run = e && !m_paused;
`ifdef LEDS_SEQ_PAUSE_EN
         if (p) m_paused = !m_paused;
`endif
         if (m || s) begin
            m_cnt = 0;
            if (s) m_speed = (m_speed + 1) % 4;
            if (m) begin
               m_mode = (m_mode + 1) % 3;
               m_sidx = 0; m_k = 0; m_ph = 1;
            end
         end else if (run) begin
            if (m_cnt == m_term()) begin
               m_cnt = 0;
               case (m_mode)
                  0:       m_sidx = (m_sidx + 1) % 14;
                  1:       m_k = (m_k + 1) % 9;
                  default: m_ph = !m_ph;
               endcase
            end else begin
               m_cnt++;
            end
         end
      end
   endtask

   // One clock: drive at negedge, check tick, apply edge to model, check state.
   task automatic cyc(input bit r, input bit e, input bit m, input bit s, input bit p = 1'b0);
      bit exp_tick;
      rst_n = r; enable = e; mode_btn = m; speed_btn = s; pause_btn = p;
      #1;
      obs_tick = tick;
      if (m_valid) begin
         exp_tick = e && !m_paused && (m_cnt == m_term());
         chk("tick", {7'd0, tick}, {7'd0, exp_tick});
      end
      @(posedge clk);
      model_edge(r, e, m, s, p);
      @(negedge clk);
      chk("leds", leds, m_leds());
      chk("mode", {6'd0, mode}, 8'(m_mode));
      chk("speed", {6'd0, speed}, 8'(m_speed));
   endtask

   logic [7:0] held;

   initial begin
      m_valid = 0; m_paused = 0;
      rst_n = 0; enable = 0; mode_btn = 0; speed_btn = 0; pause_btn = 0;
      @(negedge clk);

      // 1: reset then scan steps
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      chk("rst_leds", leds, 8'h80);
      chk("rst_tick", {7'd0, tick}, 8'h00);
      repeat (8) cyc(1, 1, 0, 0);
      chk("scan_t1", leds, 8'h40);
      repeat (48) cyc(1, 1, 0, 0);
      chk("scan_t7", leds, 8'h01);
      repeat (8) cyc(1, 1, 0, 0);
      chk("scan_t8", leds, 8'h02);
      repeat (48) cyc(1, 1, 0, 0);
      chk("scan_t14", leds, 8'h80);

      // 2: speed changes
      cyc(1, 1, 0, 1);
      repeat (4) cyc(1, 1, 0, 0);
      chk("speed1_step", leds, 8'h40);
      repeat (3) cyc(1, 1, 0, 1);
      chk("speed_wrap", {6'd0, speed}, 8'h00);

      // 3: mode walk
      cyc(1, 1, 1, 0);
      chk("fill_start", leds, 8'h00);
      repeat (64) cyc(1, 1, 0, 0);
      chk("fill_full", leds, 8'hFF);
      repeat (8) cyc(1, 1, 0, 0);
      chk("fill_wrap", leds, 8'h00);
      cyc(1, 1, 1, 0);
      chk("blink_start", leds, 8'hFF);
      repeat (8) cyc(1, 1, 0, 0);
      chk("blink_off", leds, 8'h00);
      cyc(1, 1, 1, 0);
      chk("scan_restart", leds, 8'h80);

      // 4: enable hold at cnt=5
      repeat (5) cyc(1, 1, 0, 0);
      repeat (20) cyc(1, 0, 0, 0);
      chk("hold_leds", leds, 8'h80);
      repeat (2) cyc(1, 1, 0, 0);
      chk("resume_notick", {7'd0, obs_tick}, 8'h00);
      cyc(1, 1, 0, 0);
      chk("resume_tick", {7'd0, obs_tick}, 8'h01);

      // 5: mode coincident with tick at leds=20, then reset mid-FILL
      repeat (8) cyc(1, 1, 0, 0);
      chk("scan_20", leds, 8'h20);
      repeat (7) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 0);
      chk("coinc_tick", {7'd0, obs_tick}, 8'h01);
      chk("coinc_fill", leds, 8'h00);
      repeat (10) cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 1);
      cyc(0, 1, 0, 0);
      chk("midfill_rst", leds, 8'h80);

`ifdef LEDS_SEQ_PAUSE_EN
      // 6: pause freezes, second press resumes
      repeat (3) cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0, 1);
      held = leds;
      repeat (30) cyc(1, 1, 0, 0);
      chk("pause_hold", leds, held);
      chk("pause_notick", {7'd0, obs_tick}, 8'h00);
      cyc(1, 1, 0, 0, 1);
      repeat (12) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 0, 1);
      repeat (10) cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0, 1);
`endif

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) < 85),
             ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
